// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: request/result bundle for the multi-cycle ALU.
// master drives start/alu_control/a/b; slave returns busy/done/result/zero.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, alu_control, a, b,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, alu_control, a, b,
    output busy, done, result, zero
  );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: registered handshaked ALU; add/sub/and/or/slt in one cycle.
// Ports: clk, reset_n (sync, active low), bus (slave: start, alu_control,
// a, b in; busy, done, result, zero out). MULTICYCLE_ALU_SHIFT_EN adds
// iterative sll/srl/sra (one bit per cycle); without it 100/110/111 add.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  multicycle_alu_if.slave   bus
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;
  logic [WIDTH-1:0] op_res;

  assign sum  = bus.a + bus.b;
  assign diff = bus.a - bus.b;
  assign lt   = $signed(bus.a) < $signed(bus.b);

  always_comb begin
    op_res = sum;
    unique case (bus.alu_control)
      3'b001:  op_res = diff;
      3'b010:  op_res = bus.a & bus.b;
      3'b011:  op_res = bus.a | bus.b;
      3'b101:  op_res = {{(WIDTH-1){1'b0}}, lt};
`ifdef MULTICYCLE_ALU_SHIFT_EN
      // Only reached here with a zero shift amount.
      3'b100,
      3'b110,
      3'b111:  op_res = bus.a;
`endif
      default: op_res = sum;
    endcase
  end

`ifdef MULTICYCLE_ALU_SHIFT_EN

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_nxt;
  logic [SHW-1:0]   cnt_q;
  logic [SHW-1:0]   amt;
  logic [1:0]       kind_q;
  logic             shift_req;

  assign amt = bus.b[SHW-1:0];

  // 100/110/111 are shifts; 101 is slt. A zero amount stays single-cycle.
  assign shift_req = bus.alu_control[2]
                   & (bus.alu_control[1:0] != 2'b01)
                   & (amt != '0);

  // kind_q holds alu_control[1:0]: 00 sll, 10 srl, 11 sra.
  // sra keeps the msb in place, which is bit WIDTH-1 of the original a.
  always_comb begin
    sh_nxt = sh_q << 1;
    unique case (kind_q)
      2'b10:   sh_nxt = sh_q >> 1;
      2'b11:   sh_nxt = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      default: sh_nxt = sh_q << 1;
    endcase
  end

  assign bus.busy = (state_q == SHIFT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      kind_q     <= '0;
      bus.result <= '0;
      bus.zero   <= 1'b1;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (shift_req) begin
              sh_q    <= bus.a;
              cnt_q   <= amt;
              kind_q  <= bus.alu_control[1:0];
              state_q <= SHIFT;
            end else begin
              bus.result <= op_res;
              bus.zero   <= (op_res == '0);
              bus.done   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          sh_q  <= sh_nxt;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            bus.result <= sh_nxt;
            bus.zero   <= (sh_nxt == '0);
            bus.done   <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`else

  assign bus.busy = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.result <= '0;
      bus.zero   <= 1'b1;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= bus.start;
      if (bus.start) begin
        bus.result <= op_res;
        bus.zero   <= (op_res == '0);
      end
    end
  end

`endif

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Registered, handshaked ALU that consumes the 3-bit `alu_control` code produced by the ALU decoder and executes it on two operands. Logic and arithmetic ops complete in one cycle; optional shift ops run iteratively, one bit per cycle. The block is the execution-side endpoint of the `alu_control` interface and is the ALU for the multi-cycle datapath variant of the core.

## Interface
- `WIDTH`, 32: operand and result width. Must be a power of two, at least 8.
- `SHW`, `$clog2(WIDTH)`: shift-amount width. Derived; not overridden.
- `clk`  in  1: rising-edge clock.
- `reset_n`  in  1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `start`  in  1: request strobe. Operands and code are sampled on the accepting edge.
- `alu_control`  in  3: operation code.
  - 000 add, 001 sub, 010 and, 011 or, 101 slt.
  - 100 sll, 110 srl, 111 sra (shifts require the macro).
- `a`  in  WIDTH: operand A, and the value shifted by shift ops.
- `b`  in  WIDTH: operand B. `b[SHW-1:0]` is the shift amount.
- `busy`  out  1: shift in progress. `start` is ignored while high.
- `done`  out  1: one-cycle pulse; `result` and `zero` are valid and updated.
- `result`  out  WIDTH: registered result. Holds its value until the next `done`.
- `zero`  out  1: registered `result == 0`. Updated together with `result`.

## Operation
- States: IDLE and SHIFT. Reset enters IDLE.
- Reset values: `busy`=0, `done`=0, `result`=0, `zero`=1.
- Accept rule: `start`=1 in IDLE on a rising edge.
- Single-cycle ops (add, sub, and, or, slt, and any shift with amount 0):
  - `result`, `zero` and `done`=1 are registered at the accepting edge.
  - State stays IDLE.
- Arithmetic rules:
  - add and sub wrap modulo 2^WIDTH; no overflow flag.
  - slt is a signed compare: result is 1 if `$signed(a) < $signed(b)`, else 0, zero-extended.
- Shift ops with amount k > 0:
  - Accepting edge loads the shift register with `a` and the counter with k, and enters SHIFT. `busy`=1 and `done`=0.
  - Each SHIFT edge shifts by one bit and decrements the counter.
  - On the edge where the counter goes from 1 to 0: write `result`/`zero`, pulse `done`, return to IDLE, drop `busy`.
  - sll fills with 0. srl fills with 0. sra fills with bit WIDTH-1 of `a`.
- Code 101 sub-fields are not decoded further.
- `start` while `busy` is dropped silently. No queueing; `result` is untouched.
- `done` is never asserted two cycles in a row for the same request.
- Back-to-back requests are legal: `start` may be high in the cycle where `done`=1, since `busy`=0 then.
- Reset mid-shift: the operation is aborted, no `done` is issued, and all outputs return to their reset values.

## Timing
- Request accepted in cycle N (edge at end of N):
  - Single-cycle op: `done`=1 in cycle N+1.
  - Shift with amount k: `busy`=1 in cycles N+1..N+k, `done`=1 in cycle N+1+k.
- Maximum latency is WIDTH cycles (k = WIDTH-1).
- Throughput is one single-cycle op per clock.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `MULTICYCLE_ALU_SHIFT_EN`.
- Defined:
  - SHIFT state, counter, and shift register are present.
  - Codes 100/110/111 execute sll/srl/sra as above.
- Undefined:
  - SHIFT state and shift datapath are removed; `busy` is tied 0.
  - Codes 100/110/111 execute as add with single-cycle timing. This matches the decoder's default-to-add policy.

## Test plan
- Add: reset, then `start` with code 000, a=5, b=7.
  - Expect `result`=12, `zero`=0, `done`=1 exactly one cycle later.
- Sub, non-zero and zero:
  - Code 001, a=3, b=5: expect `result`=0xFFFFFFFE, `zero`=0.
  - Then code 001, a=9, b=9 in the next cycle: expect `result`=0, `zero`=1, on consecutive `done` pulses.
- Logic and slt:
  - Code 010, a=0xF0F0_F0F0, b=0xFF00_FF00: expect 0xF000_F000.
  - Code 011 with the same operands: expect 0xFFF0_FFF0.
  - Code 101, a=0xFFFF_FFFF, b=1: expect 1 (signed).
- Sra with a busy-time request (macro defined):
  - Code 111, a=0x8000_0000, b=4: expect `busy` high for 4 cycles, then `done` with 0xF800_0000.
  - A `start` with code 000 issued during `busy` is ignored: no extra `done`, and `result` is unchanged until the shift's `done`.
- Zero-amount shift and macro off:
  - Code 100, a=0x1234, b=0: expect `result`=0x1234 after 1 cycle.
  - With the macro undefined, code 100, a=2, b=3: expect `result`=5 after 1 cycle, with `busy` never asserted.
- Reset mid-shift:
  - Start code 110, a=0xFFFF_FFFF, b=20; pull `reset_n` low in the third busy cycle.
  - Expect `busy`=0, `done`=0, `result`=0 and `zero`=1 after that edge, and no late `done`.
